// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM states and the iteration count.
package mdu_pkg;

    localparam int ITER = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling: operand magnitude extraction on entry and
// result negation on exit, shared by the multiply and divide paths.
module mdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               sign_a,
    output logic               sign_b,
    input  logic               is_div,
    input  logic               neg_lo,
    input  logic               neg_hi,
    input  logic [2*WIDTH-1:0] res_in,
    output logic [2*WIDTH-1:0] res_out
);

    assign sign_a = signed_op & a_in[WIDTH-1];
    assign sign_b = signed_op & b_in[WIDTH-1];
    assign mag_a  = sign_a ? -a_in : a_in;
    assign mag_b  = sign_b ? -b_in : b_in;

    // A product negates as one double-width value; quotient and remainder negate independently.
    always_comb begin
        res_out = res_in;
        if (is_div) begin
            res_out[2*WIDTH-1:WIDTH] = neg_hi ? -res_in[2*WIDTH-1:WIDTH] : res_in[2*WIDTH-1:WIDTH];
            res_out[WIDTH-1:0]       = neg_lo ? -res_in[WIDTH-1:0] : res_in[WIDTH-1:0];
        end else if (neg_lo) begin
            res_out = -res_in;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring-subtract
// step per cycle, sign correction in a final FIX cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITER);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] shf_q, shf_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH-1:0] raw_a_q, raw_a_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               sign_a, sign_b;
    logic [2*WIDTH-1:0] fixed_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;

    mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .signed_op (~op[2] & ~op[0]),
        .a_in      (src_a),
        .b_in      (src_b),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .sign_a    (sign_a),
        .sign_b    (sign_b),
        .is_div    (is_div_q),
        .neg_lo    (neg_lo_q),
        .neg_hi    (neg_hi_q),
        .res_in    ({acc_q[WIDTH-1:0], shf_q}),
        .res_out   (fixed_res)
    );

    // acc holds the running high word / partial remainder, shf the multiplier / dividend-quotient.
    assign mul_sum   = shf_q[0] ? (acc_q + {1'b0, opd_q}) : acc_q;
    assign div_shift = {acc_q[WIDTH-1:0], shf_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opd_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        acc_d      = acc_q;
        shf_d      = shf_q;
        opd_d      = opd_q;
        raw_a_d    = raw_a_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        div_zero_d = div_zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op <= OP_DIVU) begin
                        state_d    = S_RUN;
                        busy_d     = 1'b1;
                        cnt_d      = '0;
                        acc_d      = '0;
                        raw_a_d    = src_a;
                        is_div_d   = op[1];
                        neg_lo_d   = sign_a ^ sign_b;
                        neg_hi_d   = sign_a;
                        div_zero_d = (src_b == '0);
                        shf_d      = op[1] ? mag_a : mag_b;
                        opd_d      = op[1] ? mag_b : mag_a;
                    end else if (op == OP_MTHI) begin
                        hi_d = src_a;
                    end else if (op == OP_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    acc_d = div_ge ? (div_shift - {1'b0, opd_q}) : div_shift;
                    shf_d = {shf_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {1'b0, mul_sum[WIDTH:1]};
                    shf_d = {mul_sum[0], shf_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                cnt_d   = '0;
                // Divide by zero reports the original dividend untouched by sign correction.
                if (is_div_q && div_zero_q) begin
                    hi_d = raw_a_q;
                    lo_d = '1;
                end else begin
                    hi_d = fixed_res[2*WIDTH-1:WIDTH];
                    lo_d = fixed_res[WIDTH-1:0];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            acc_q      <= '0;
            shf_q      <= '0;
            opd_q      <= '0;
            raw_a_q    <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            acc_q      <= acc_d;
            shf_q      <= shf_d;
            opd_q      <= opd_d;
            raw_a_q    <= raw_a_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed table-driven bench for mult_div_unit with hand-computed results
// plus sequences for MTHI/MTLO, ignored starts, back-to-back and reset abort.
module tb_mult_div_unit;
    import mdu_pkg::*;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vectors = 0;
    int n_miscompares = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Present a request for the coming edge, then drop start one negedge later.
    task automatic startNow(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        startNow(o, a, b);
    endtask

    // Wait (bounded) for done, counting busy cycles and checking hi/lo stay frozen meanwhile.
    task automatic waitDone(input string name, input int inject_at, output int busy_cycles);
        int          cycles;
        logic        held;
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0 = hi;
        lo0 = lo;
        held = 1'b1;
        busy_cycles = 0;
        cycles = 0;
        while (!done && cycles < 60) begin
            if (busy) busy_cycles++;
            if (hi !== hi0 || lo !== lo0) held = 1'b0;
            start = (cycles == inject_at);
            if (cycles == inject_at) begin
                op    = OP_DIVU;
                src_a = 32'd100;
                src_b = 32'd3;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        checkOutput({name, " done_seen"}, 64'(done), 64'd1);
        checkOutput({name, " hilo_held"}, 64'(held), 64'd1);
    endtask

    initial begin
        vec_t vecs[13];
        int   bc;
        int   done_seen;

        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[5]  = '{OP_DIV,   32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF};
        vecs[6]  = '{OP_MULT,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[7]  = '{OP_MULT,  32'hFFFFFFFC, 32'hFFFFFFFB, 32'h00000000, 32'd20};
        vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[9]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};
        vecs[10] = '{OP_MULTU, 32'h12345678, 32'h100,      32'h00000012, 32'h34567800};
        vecs[11] = '{OP_DIV,   32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14};
        vecs[12] = '{OP_MULTU, 32'h80000000, 32'd2,        32'd1,        32'd0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset hi",   64'(hi),   64'd0);
        checkOutput("reset lo",   64'(lo),   64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);

        // MTHI then MTLO on consecutive cycles: single-edge writes, no busy/done.
        @(negedge clk);
        start = 1'b1; op = OP_MTHI; src_a = 32'h12345678;
        @(negedge clk);
        checkOutput("mthi hi", 64'(hi), 64'h12345678);
        checkOutput("mthi lo", 64'(lo), 64'd0);
        checkOutput("mthi busy/done", 64'({busy, done}), 64'd0);
        op = OP_MTLO; src_a = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("mtlo lo", 64'(lo), 64'h9ABCDEF0);
        checkOutput("mtlo hi", 64'(hi), 64'h12345678);
        checkOutput("mtlo busy/done", 64'({busy, done}), 64'd0);
        @(negedge clk);
        checkOutput("mt idle busy/done", 64'({busy, done}), 64'd0);

        // Reserved op leaves everything alone.
        applyStimulus(3'd6, 32'hDEADBEEF, 32'd1);
        checkOutput("op6 hi", 64'(hi), 64'h12345678);
        checkOutput("op6 lo", 64'(lo), 64'h9ABCDEF0);
        checkOutput("op6 busy", 64'(busy), 64'd0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            waitDone($sformatf("vec%0d", i), -1, bc);
            checkOutput($sformatf("vec%0d busy_cycles", i), 64'(bc), 64'd33);
            checkOutput($sformatf("vec%0d hi", i), 64'(hi), 64'(vecs[i].exp_hi));
            checkOutput($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].exp_lo));
            checkOutput($sformatf("vec%0d busy_in_done", i), 64'(busy), 64'd0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d done_pulse", i), 64'(done), 64'd0);
            checkOutput($sformatf("vec%0d hi_kept", i), 64'(hi), 64'(vecs[i].exp_hi));
        end

        // MULTU 7x6 with a DIVU start arriving mid-run that must be ignored.
        applyStimulus(OP_MULTU, 32'd7, 32'd6);
        waitDone("ignore", 4, bc);
        checkOutput("ignore busy_cycles", 64'(bc), 64'd33);
        checkOutput("ignore hi", 64'(hi), 64'd0);
        checkOutput("ignore lo", 64'(lo), 64'd42);

        // Back-to-back: new request in the done cycle.
        startNow(OP_MULTU, 32'd3, 32'd5);
        checkOutput("b2b busy", 64'(busy), 64'd1);
        waitDone("b2b", -1, bc);
        checkOutput("b2b busy_cycles", 64'(bc), 64'd33);
        checkOutput("b2b lo", 64'(lo), 64'd15);

        // Reset in RUN aborts without committing a result.
        applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd5);
        repeat (9) @(negedge clk);
        checkOutput("abort busy before rst", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort hi", 64'(hi), 64'd0);
        checkOutput("abort lo", 64'(lo), 64'd0);
        checkOutput("abort busy/done", 64'({busy, done}), 64'd0);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        checkOutput("abort no_done", 64'(done_seen), 64'd0);
        checkOutput("abort lo_after", 64'(lo), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle HI/LO multiply/divide unit for the MIPS core.
- Sits directly downstream of the register file: consumes its two read-data outputs (rs, rt) as src_a/src_b.
- Executes MULT, MULTU, DIV, DIVU iteratively and MTHI/MTLO in one cycle.
- Holds the HI/LO architectural registers; busy stalls decode so that MFHI/MFLO never read stale values.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request an operation this cycle
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6 and 7 are reserved
- src_a  input  WIDTH  rs value from the register file: multiplicand, dividend, or MTHI/MTLO data
- src_b  input  WIDTH  rt value from the register file: multiplier or divisor
- busy  output  1  iterative operation in progress; decode stalls while high
- done  output  1  one-cycle pulse; HI/LO updated in the same cycle
- hi  output  WIDTH  HI register (product high word or remainder)
- lo  output  WIDTH  LO register (product low word or quotient)

Behaviour:
- Reset (synchronous, any state): hi=0, lo=0, busy=0, done=0, FSM to IDLE, iteration counter=0. Aborts any operation in flight; no partial result is committed.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start=1 with op 0..3 at edge E0: latch operands, state to RUN, busy=1 after E0.
  - For signed ops (0, 2), latch the magnitudes of src_a/src_b and record result-sign flags.
- RUN:
  - One shift-add (multiply) or restoring-subtract (divide) step per cycle at edges E1..E32.
  - Counter 0..31; after E32 go to FIX.
- FIX:
  - At E33, apply sign correction and write hi/lo.
  - done=1 and busy=0 after E33; return to IDLE.
  - done is a single cycle; it clears at E34 unless a new operation finishes then.
- Latency: start sampled at E0; result visible and done high in cycle E33..E34. busy is high for exactly 33 cycles.
- MTHI/MTLO: start with op 4/5 in IDLE writes src_a to hi/lo at E0. No busy, no done; the other register is unchanged.
- Back-to-back: a start in the done cycle (busy=0) is accepted.
- start while busy=1 is ignored; operands and op are not re-latched.
- op 6/7 is ignored; no state change.
- Multiply: {hi,lo} receives the 2*WIDTH-bit product.
  - MULT: the product is negated when the operand signs differ.
  - MULTU: unsigned product.
- Divide: lo receives the quotient, hi the remainder.
  - DIV: quotient negated if the signs differ; remainder takes the sign of the dividend.
  - Overflow case, -2^31 / -1: lo=0x80000000, hi=0.
- Divide by zero (DIV and DIVU): lo=all ones, hi=src_a as latched (original signed value), with no sign correction. It still takes the full 33 cycles.
- hi/lo hold their previous values for the whole of busy and change only at the FIX edge or on MTHI/MTLO.

Decomposition:
- Shared package mdu_pkg:
  - op encodings OP_MULT..OP_MTLO
  - FSM state enum
  - ITER = WIDTH, the iteration count
- One natural sub-module, mdu_sign_fix: combinational magnitude extraction and final negation, reused for both multiply and divide results.
- FSM, counter and shift datapath stay in mult_div_unit.

Test Plan:
- MULT src_a=0xFFFFFFFD (-3), src_b=5 -> busy high 33 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100; DIV 0xFFFFFF9C / 0 -> lo=0xFFFFFFFF, hi=0xFFFFFF9C.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge after each, busy and done never asserted.
- Start MULTU 7x6:
  - A second start (DIVU) at cycle 5 is ignored; result hi=0, lo=42.
  - Next run: rst at RUN cycle 10 -> the following cycle shows hi=0, lo=0, busy=0, done=0, and no done pulse follows.
